// File: rtl/streaming_result_accumulator.sv
// rtl/streaming_result_accumulator.sv - per-top accumulator of 2^connectCount and valid-slot count
//
// Consumes one result slot per clock (no backpressure). It sums 2^connectCount
// and counts the valid slots of each top. On the last slot of a top it emits one
// result word with a one-cycle sumValid pulse, three cycles after that slot.
//
// Optional feature macro: RESULT_ACCUMULATOR_OVERFLOW_CHECK_EN
//   defined   : overflow is a sticky per-top flag. It is set by a carry out of the
//               sum add, or by a valid slot whose count is outside the accumulator.
//   undefined : overflow is tied to 0 and out-of-range counts add nothing.
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   resultValid   slot carries a valid bot result
//   connectCount  connected-component count of the slot
//   resultIsLast  slot closes the current top (honoured even when not valid)
//   topTagIn      tag of the current top, captured on the last slot
//   eccIn         ECC error pulse from the upstream core
//   sumValid      one-cycle pulse qualifying sumOut/countOut/tagOut/eccOut/overflow
//   sumOut        sum of 2^connectCount over the valid slots of the top
//   countOut      number of valid slots in the top
//   tagOut        tag captured on the last slot
//   eccOut        OR of eccIn over the slots of the top
//   overflow      per-top overflow flag (0 when the feature is not built)
module streaming_result_accumulator #(
  parameter int ACC_WIDTH   = 64,
  parameter int COUNT_WIDTH = 32,
  parameter int TAG_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   resultValid,
  input  logic [5:0]             connectCount,
  input  logic                   resultIsLast,
  input  logic [TAG_WIDTH-1:0]   topTagIn,
  input  logic                   eccIn,
  output logic                   sumValid,
  output logic [ACC_WIDTH-1:0]   sumOut,
  output logic [COUNT_WIDTH-1:0] countOut,
  output logic [TAG_WIDTH-1:0]   tagOut,
  output logic                   eccOut,
  output logic                   overflow
);

  localparam logic [ACC_WIDTH-1:0] ONE = {{(ACC_WIDTH-1){1'b0}}, 1'b1};

  // Stage 0: registered inputs
  logic                 r0_valid;
  logic [5:0]           r0_count;
  logic                 r0_last;
  logic [TAG_WIDTH-1:0] r0_tag;
  logic                 r0_ecc;

  // Stage 1: decoded addend plus the control fields carried along
  logic [ACC_WIDTH-1:0] r1_addend;
  logic                 r1_valid;
  logic                 r1_last;
  logic [TAG_WIDTH-1:0] r1_tag;
  logic                 r1_ecc;

  // Stage 2: running per-top state and the output word
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic                   r_ecc_acc;
  logic                   r_sum_valid;
  logic [ACC_WIDTH-1:0]   r_sum_out;
  logic [COUNT_WIDTH-1:0] r_count_out;
  logic [TAG_WIDTH-1:0]   r_tag_out;
  logic                   r_ecc_out;

  logic                   w_in_range;
  logic [ACC_WIDTH-1:0]   w_sum;
  logic [COUNT_WIDTH-1:0] w_cnt;
  logic                   w_ecc;

  // Counts at or above the accumulator width have no bit to land in.
  assign w_in_range = ({26'd0, r0_count} < ACC_WIDTH);
  assign w_cnt      = r_cnt + {{(COUNT_WIDTH-1){1'b0}}, r1_valid};
  assign w_ecc      = r_ecc_acc | r1_ecc;

`ifdef RESULT_ACCUMULATOR_OVERFLOW_CHECK_EN
  logic                 r1_oor;
  logic                 r_ovf_acc;
  logic                 r_overflow;
  logic [ACC_WIDTH:0]   w_sum_ext;
  logic                 w_ovf;

  assign w_sum_ext = {1'b0, r_acc} + {1'b0, r1_addend};
  assign w_sum     = w_sum_ext[ACC_WIDTH-1:0];
  assign w_ovf     = r_ovf_acc | w_sum_ext[ACC_WIDTH] | r1_oor;
  assign overflow  = r_overflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_oor     <= 1'b0;
      r_ovf_acc  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r1_oor <= r0_valid & ~w_in_range;
      // Sticky within a top, reported with the word and cleared for the next top.
      r_ovf_acc <= r1_last ? 1'b0 : w_ovf;
      if (r1_last) begin
        r_overflow <= w_ovf;
      end
    end
  end
`else
  assign w_sum    = r_acc + r1_addend;
  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r0_valid    <= 1'b0;
      r0_count    <= '0;
      r0_last     <= 1'b0;
      r0_tag      <= '0;
      r0_ecc      <= 1'b0;
      r1_addend   <= '0;
      r1_valid    <= 1'b0;
      r1_last     <= 1'b0;
      r1_tag      <= '0;
      r1_ecc      <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ecc_acc   <= 1'b0;
      r_sum_valid <= 1'b0;
      r_sum_out   <= '0;
      r_count_out <= '0;
      r_tag_out   <= '0;
      r_ecc_out   <= 1'b0;
    end else begin
      r0_valid <= resultValid;
      r0_count <= connectCount;
      r0_last  <= resultIsLast;
      r0_tag   <= topTagIn;
      r0_ecc   <= eccIn;

      r1_addend <= (r0_valid && w_in_range) ? (ONE << r0_count) : '0;
      r1_valid  <= r0_valid;
      r1_last   <= r0_last;
      r1_tag    <= r0_tag;
      r1_ecc    <= r0_ecc;

      // Clearing on the last slot lets the next slot start a fresh top with no bubble.
      r_acc       <= r1_last ? '0 : w_sum;
      r_cnt       <= r1_last ? '0 : w_cnt;
      r_ecc_acc   <= r1_last ? 1'b0 : w_ecc;
      r_sum_valid <= r1_last;
      if (r1_last) begin
        r_sum_out   <= w_sum;
        r_count_out <= w_cnt;
        r_tag_out   <= r1_tag;
        r_ecc_out   <= w_ecc;
      end
    end
  end

  assign sumValid = r_sum_valid;
  assign sumOut   = r_sum_out;
  assign countOut = r_count_out;
  assign tagOut   = r_tag_out;
  assign eccOut   = r_ecc_out;

endmodule

// File: tb/tb_streaming_result_accumulator.sv
// tb/tb_streaming_result_accumulator.sv - self-checking bench for streaming_result_accumulator
module tb_streaming_result_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        resultValid = 1'b0;
  logic [5:0]  connectCount = '0;
  logic        resultIsLast = 1'b0;
  logic [7:0]  topTagIn = '0;
  logic        eccIn = 1'b0;
  logic        sumValid;
  logic [63:0] sumOut;
  logic [31:0] countOut;
  logic [7:0]  tagOut;
  logic        eccOut;
  logic        overflow;

  streaming_result_accumulator #(.ACC_WIDTH(64), .COUNT_WIDTH(32), .TAG_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .resultValid(resultValid), .connectCount(connectCount),
    .resultIsLast(resultIsLast), .topTagIn(topTagIn), .eccIn(eccIn),
    .sumValid(sumValid), .sumOut(sumOut), .countOut(countOut), .tagOut(tagOut),
    .eccOut(eccOut), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] sum;
    logic [31:0] cnt;
    logic [7:0]  tag;
    logic        ecc;
    logic        ovf;
    int          at;
  } exp_t;

  typedef struct {
    logic        v;
    logic [5:0]  c;
    logic        l;
    logic [7:0]  tg;
    logic        e;
    logic [63:0] sum;
    logic [31:0] cnt;
    logic        ecc;
    logic        ovf_on;
  } vec_t;

  exp_t sb[$];
  exp_t held = '{sum: '0, cnt: '0, tag: '0, ecc: 1'b0, ovf: 1'b0, at: 0};
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on every pulse, otherwise checks that
  // the outputs hold (or read zero while in reset).
  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_outputs", {63'd0, sumValid, sumOut, countOut, tagOut, eccOut, overflow}, '0);
      held = '{sum: '0, cnt: '0, tag: '0, ecc: 1'b0, ovf: 1'b0, at: 0};
    end else if (sumValid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got sumValid=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        exp_t ex;
        ex = sb.pop_front();
        chk("latency", 128'(cyc), 128'(ex.at + 3));
        chk("sum", 128'(sumOut), 128'(ex.sum));
        chk("count", 128'(countOut), 128'(ex.cnt));
        chk("tag", 128'(tagOut), 128'(ex.tag));
        chk("ecc", 128'(eccOut), 128'(ex.ecc));
        chk("overflow", 128'(overflow), 128'(ex.ovf));
        held = ex;
      end
    end else begin
      chk("hold", {eccOut, overflow, tagOut, countOut, sumOut},
          {held.ecc, held.ovf, held.tag, held.cnt, held.sum});
    end
  end

  task automatic drive(input logic v, input logic [5:0] c, input logic l, input logic [7:0] tg,
                       input logic e, input logic [63:0] s, input logic [31:0] n,
                       input logic ec, input logic ovf_on);
    exp_t ex;
    resultValid  = v;
    connectCount = c;
    resultIsLast = l;
    topTagIn     = tg;
    eccIn        = e;
    if (l) begin
      ex.sum = s;
      ex.cnt = n;
      ex.tag = tg;
      ex.ecc = ec;
`ifdef RESULT_ACCUMULATOR_OVERFLOW_CHECK_EN
      ex.ovf = ovf_on;
`else
      ex.ovf = 1'b0;
`endif
      ex.at  = cyc;
      sb.push_back(ex);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 6'd0, 1'b0, 8'h00, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  vec_t tbl[$];

  task automatic add(input logic v, input logic [5:0] c, input logic l, input logic [7:0] tg,
                     input logic e, input logic [63:0] s, input logic [31:0] n,
                     input logic ec, input logic ovf_on);
    vec_t r;
    r = '{v: v, c: c, l: l, tg: tg, e: e, sum: s, cnt: n, ecc: ec, ovf_on: ovf_on};
    tbl.push_back(r);
  endtask

  initial begin
    // Top A: counts 0,1,2,5 -> 1+2+4+32 = 0x27
    add(1, 0, 0, 8'h11, 0, 0, 0, 0, 0);
    add(1, 1, 0, 8'h11, 0, 0, 0, 0, 0);
    add(1, 2, 0, 8'h11, 0, 0, 0, 0, 0);
    add(1, 5, 1, 8'h11, 0, 64'h27, 4, 0, 0);
    // Top B: invalid slots interleaved, ecc on slot 2 -> 3*16 = 48
    add(1, 4, 0, 8'h22, 0, 0, 0, 0, 0);
    add(0, 9, 0, 8'h22, 1, 0, 0, 0, 0);
    add(1, 4, 0, 8'h22, 0, 0, 0, 0, 0);
    add(0, 0, 0, 8'h22, 0, 0, 0, 0, 0);
    add(1, 4, 0, 8'h22, 0, 0, 0, 0, 0);
    add(0, 0, 1, 8'h22, 0, 64'd48, 3, 1, 0);
    // Back-to-back single-slot tops
    add(1, 7, 1, 8'h33, 0, 64'd128, 1, 0, 0);
    add(1, 9, 1, 8'h34, 0, 64'd512, 1, 0, 0);
    // Empty top
    add(0, 5, 1, 8'h40, 0, 64'd0, 0, 0, 0);
    // ECC pulse on the last slot itself
    add(1, 0, 0, 8'h41, 0, 0, 0, 0, 0);
    add(1, 0, 1, 8'h41, 1, 64'd2, 2, 1, 0);
    // Highest bit alone: no carry
    add(1, 63, 1, 8'h42, 0, 64'h8000_0000_0000_0000, 1, 0, 0);
    // Carry out of the accumulator, then a clean top
    add(1, 63, 0, 8'h50, 0, 0, 0, 0, 0);
    add(1, 63, 1, 8'h50, 0, 64'd0, 2, 0, 1);
    add(1, 0, 1, 8'h51, 0, 64'd1, 1, 0, 0);

    // Reset held with random inputs: no output activity
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      resultValid  = 1'($urandom);
      connectCount = 6'($urandom);
      resultIsLast = 1'($urandom);
      topTagIn     = 8'($urandom);
      eccIn        = 1'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    drive(1, 3, 1, 8'h07, 0, 64'd8, 1, 0, 0);
    idle(4);

    foreach (tbl[i])
      drive(tbl[i].v, tbl[i].c, tbl[i].l, tbl[i].tg, tbl[i].e,
            tbl[i].sum, tbl[i].cnt, tbl[i].ecc, tbl[i].ovf_on);
    idle(5);

    // Mid-top reset discards the partial top
    for (int i = 0; i < 5; i++) drive(1, 2, 0, 8'h60, 0, 0, 0, 0, 0);
    rst = 1'b0;
    resultValid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1, 1, 0, 8'h61, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 8'h61, 0, 64'd4, 2, 0, 0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding results expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
